// File: rtl/mem_access_pkg.sv
// Shared Y86-64 constants for the memory stage: word width, icodes,
// status codes and the memory-stage FSM encoding.
package mem_access_pkg;

  localparam int QWORD = 64;
  typedef logic [QWORD-1:0] qword_t;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mem_access_ctl_decode.sv
// Combinational decode of an instruction into its data-memory access:
// direction, byte address and write data.
module mem_ctl_decode
  import mem_access_pkg::*;
(
  input  logic [3:0] icode,
  input  qword_t     valE,
  input  qword_t     valA,
  input  qword_t     valP,
  output logic       is_read,
  output logic       is_write,
  output qword_t     addr,
  output qword_t     wdata
);

  always_comb begin
    is_read  = 1'b0;
    is_write = 1'b0;
    addr     = valE;
    wdata    = valA;
    unique case (icode)
      IRMMOVQ, IPUSHQ: is_write = 1'b1;
      ICALL: begin
        is_write = 1'b1;
        wdata    = valP;
      end
      IMRMOVQ: is_read = 1'b1;
      // Pops and returns read from the old stack pointer, not valE.
      IPOPQ, IRET: begin
        is_read = 1'b1;
        addr    = valA;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Y86-64 SEQ memory stage: captures one instruction, runs a req/ack access
// to data memory with a timeout, and reports valM/stat with a done pulse.
// Handshake: in_valid is accepted only on a clock edge where in_ready=1 (IDLE);
// mem_req stays high with stable we/addr/wdata until the edge mem_ack=1 or the
// timeout expires; mem_ack outside REQ is ignored.
module mem_access
  import mem_access_pkg::*;
#(
  parameter longint unsigned MEM_BYTES = 65536,
  parameter int unsigned     TIMEOUT   = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] icode,
  input  logic       instr_valid,
  input  qword_t     valE,
  input  qword_t     valA,
  input  qword_t     valP,
  output logic       mem_req,
  output logic       mem_we,
  output qword_t     mem_addr,
  output qword_t     mem_wdata,
  input  qword_t     mem_rdata,
  input  logic       mem_ack,
  output qword_t     valM,
  output logic [2:0] stat,
  output logic       done,
  output state_t     fsm_state
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q;
  logic       is_read_q;

  logic   dec_read, dec_write;
  qword_t dec_addr, dec_wdata;

  mem_ctl_decode u_decode (
    .icode    (icode),
    .valE     (valE),
    .valA     (valA),
    .valP     (valP),
    .is_read  (dec_read),
    .is_write (dec_write),
    .addr     (dec_addr),
    .wdata    (dec_wdata)
  );

  logic mem_op, addr_fault, start_req, timeout_hit;
  assign mem_op      = dec_read | dec_write;
  assign addr_fault  = mem_op && (dec_addr >= MEM_BYTES);
  assign start_req   = instr_valid && mem_op && !addr_fault;
  assign timeout_hit = (cnt_q == TO_LAST);

  assign in_ready  = (state_q == ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign fsm_state = state_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (in_valid) state_d = start_req ? ST_REQ : ST_DONE;
      ST_REQ:  if (mem_ack || timeout_hit) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      valM      <= '0;
      stat      <= SAOK;
      cnt_q     <= '0;
      is_read_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: if (in_valid) begin
          is_read_q <= dec_read && start_req;
          cnt_q     <= '0;
          if (start_req) begin
            mem_req   <= 1'b1;
            mem_we    <= dec_write;
            mem_addr  <= dec_addr;
            mem_wdata <= dec_wdata;
            if (!dec_read) valM <= '0;
          end else begin
            valM <= '0;
            if (!instr_valid)        stat <= SINS;
            else if (addr_fault)     stat <= SADR;
            else if (icode == IHALT) stat <= SHLT;
            else                     stat <= SAOK;
          end
        end
        ST_REQ: begin
          // An ack in the timeout cycle still completes the access.
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            cnt_q   <= '0;
            stat    <= SAOK;
            if (is_read_q) valM <= mem_rdata;
          end else if (timeout_hit) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            cnt_q   <= '0;
            stat    <= SADR;
            if (is_read_q) valM <= '0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: a driver plays execute and memory, a
// scoreboard queue holds the expected {stat, valM} for every done pulse.
module tb_mem_access;
  import mem_access_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] icode = 4'h1;
  logic       instr_valid = 1'b1;
  qword_t     valE = '0, valA = '0, valP = '0;
  logic       mem_req, mem_we;
  qword_t     mem_addr, mem_wdata;
  qword_t     mem_rdata = '0;
  logic       mem_ack = 1'b0;
  qword_t     valM;
  logic [2:0] stat;
  logic       done;
  state_t     fsm_state;

  int n_vec = 0;
  int n_err = 0;
  logic [66:0] exp_q[$];

  mem_access dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .icode(icode), .instr_valid(instr_valid), .valE(valE), .valA(valA),
    .valP(valP), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .valM(valM), .stat(stat), .done(done), .fsm_state(fsm_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        logic [66:0] e;
        e = exp_q.pop_front();
        check("stat", 64'(stat), 64'(e[66:64]));
        check("valM", valM, e[63:0]);
      end
    end
  end

  // Driver: issue one instruction, answer memory after ack_after REQ cycles
  // (0 = never), then check request contents, request length and latency.
  task automatic run_op(
    input string name, input logic [3:0] ic, input logic iv,
    input qword_t ve, input qword_t va, input qword_t vp,
    input int ack_after, input qword_t rdata,
    input logic exp_we, input qword_t exp_addr, input qword_t exp_wdata,
    input int exp_req, input int exp_lat,
    input logic [2:0] exp_stat, input qword_t exp_valm);
    int req_cnt, lat;
    bit seen;
    @(negedge clk);
    check({name, "_in_ready"}, 64'(in_ready), 64'd1);
    icode = ic; instr_valid = iv; valE = ve; valA = va; valP = vp;
    in_valid = 1'b1;
    exp_q.push_back({exp_stat, exp_valm});
    @(posedge clk);
    #1 in_valid = 1'b0;
    req_cnt = 0; lat = 0; seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      mem_ack = 1'b0;
      lat++;
      if (done) begin
        seen = 1;
        break;
      end
      if (mem_req) begin
        req_cnt++;
        if (req_cnt == 1) begin
          check({name, "_we"}, 64'(mem_we), 64'(exp_we));
          check({name, "_addr"}, mem_addr, exp_addr);
          if (exp_we) check({name, "_wdata"}, mem_wdata, exp_wdata);
        end
        if (req_cnt == ack_after) begin
          mem_ack = 1'b1;
          mem_rdata = rdata;
        end
      end
    end
    check({name, "_done_seen"}, 64'(seen), 64'd1);
    check({name, "_req_cycles"}, 64'(req_cnt), 64'(exp_req));
    check({name, "_latency"}, 64'(lat), 64'(exp_lat));
    @(negedge clk);
    check({name, "_done_once"}, 64'(done), 64'd0);
  endtask

  initial begin
    // Reset block
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_mem_addr", mem_addr, 64'd0);
    check("rst_mem_wdata", mem_wdata, 64'd0);
    check("rst_valM", valM, 64'd0);
    check("rst_stat", 64'(stat), 64'(SAOK));
    check("rst_done", 64'(done), 64'd0);
    check("rst_state", 64'(fsm_state), 64'(ST_IDLE));
    rst = 1'b0;

    //       name      icode    iv  valE                   valA      valP   ack rdata        we addr       wdata  req lat stat  valM
    run_op("read",    IMRMOVQ, 1, 64'h100,               64'h0,    64'h0,  1, 64'hDEADBEEF, 0, 64'h100,   64'h0,  1, 2, SAOK, 64'hDEADBEEF);
    run_op("timeout", IMRMOVQ, 1, 64'h300,               64'h0,    64'h0,  0, 64'h0,        0, 64'h300,   64'h0, 15, 16, SADR, 64'h0);
    run_op("call",    ICALL,   1, 64'h1F8,               64'h9,    64'h40, 3, 64'h0,        1, 64'h1F8,   64'h40, 3, 4, SAOK, 64'h0);
    run_op("pop",     IPOPQ,   1, 64'h208,               64'h200,  64'h0,  1, 64'h55,       0, 64'h200,   64'h0,  1, 2, SAOK, 64'h55);

    // Stray ack in IDLE must not disturb anything
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 64'hBAD;
    repeat (2) @(negedge clk);
    mem_ack = 1'b0;
    check("stray_done", 64'(done), 64'd0);
    check("stray_req", 64'(mem_req), 64'd0);
    check("stray_ready", 64'(in_ready), 64'd1);
    check("stray_valM", valM, 64'h55);

    run_op("push_wrap", IPUSHQ, 1, 64'hFFFFFFFFFFFFFFF8, 64'h7,   64'h0,  1, 64'h0,        1, 64'h0,     64'h0,  0, 1, SADR, 64'h0);
    run_op("ret_ack15", IRET,   1, 64'h88,               64'h80,  64'h0, 15, 64'h1234,     0, 64'h80,    64'h0, 15, 16, SAOK, 64'h1234);
    run_op("opq",       IOPQ,   1, 64'h5,                64'h3,   64'h0,  1, 64'h0,        0, 64'h0,     64'h0,  0, 1, SAOK, 64'h0);
    run_op("halt",      IHALT,  1, 64'h0,                64'h0,   64'h0,  1, 64'h0,        0, 64'h0,     64'h0,  0, 1, SHLT, 64'h0);
    run_op("illegal",   IMRMOVQ,0, 64'h100,              64'h0,   64'h0,  1, 64'h0,        0, 64'h0,     64'h0,  0, 1, SINS, 64'h0);
    run_op("wr_last",   IRMMOVQ,1, 64'hFFFF,             64'hAB,  64'h0,  2, 64'h0,        1, 64'hFFFF,  64'hAB, 2, 3, SAOK, 64'h0);
    run_op("wr_edge",   IRMMOVQ,1, 64'h10000,            64'hAB,  64'h0,  1, 64'h0,        1, 64'h0,     64'h0,  0, 1, SADR, 64'h0);

    // Reset during the second REQ cycle: request drops, no done
    @(negedge clk);
    icode = IMRMOVQ; instr_valid = 1'b1; valE = 64'h100; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("rstreq_req1", 64'(mem_req), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rstreq_req", 64'(mem_req), 64'd0);
    check("rstreq_ready", 64'(in_ready), 64'd1);
    check("rstreq_done", 64'(done), 64'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access.md
# mem_access

Y86-64 SEQ memory stage, directly downstream of the execute stage. Latches one instruction's `icode`, `valE`, `valA`, `valP` from execute and decides whether to read, write or skip data memory. Drives a request/acknowledge handshake to the data memory and returns `valM` with a status code and a one-cycle `done` pulse to write-back/PC-update. Unacknowledged or out-of-range accesses become an address-error status.

## Interface
- `MEM_BYTES`, default 65536: valid data-memory size in bytes; addresses `>= MEM_BYTES` fault.
- `TIMEOUT`, default 15: max `REQ` cycles without `mem_ack` before faulting; range 1..255.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: execute results valid this cycle.
- `in_ready` out 1: stage idle and can accept.
- `icode` in 4: instruction code (`defines.vh` constants).
- `instr_valid` in 1: 0 means fetch flagged an illegal instruction.
- `valE` in `QWORD`: ALU result.
- `valA` in `QWORD`: register A value.
- `valP` in `QWORD`: next-PC value.
- `mem_req` out 1: memory request.
- `mem_we` out 1: 1 = write, 0 = read.
- `mem_addr` out `QWORD`: byte address.
- `mem_wdata` out `QWORD`: write data.
- `mem_rdata` in `QWORD`: read data, valid with `mem_ack`.
- `mem_ack` in 1: memory completes the request this cycle.
- `valM` out `QWORD`: read result; 0 for non-read instructions.
- `stat` out 3: `SAOK`=1, `SHLT`=2, `SADR`=3, `SINS`=4.
- `done` out 1: one-cycle pulse; `valM`/`stat` valid while high.

## Operation
- **Address select:**
  - `valE` for `IRMMOVQ`, `IMRMOVQ`, `IPUSHQ`, `ICALL`.
  - `valA` for `IPOPQ`, `IRET`.
- **Read:** `IMRMOVQ`, `IPOPQ`, `IRET`.
- **Write:**
  - `IRMMOVQ`, `IPUSHQ` write `valA`.
  - `ICALL` writes `valP`.
- All other icodes make no memory access.
- **FSM states `IDLE`, `REQ`, `DONE`:**
  - `IDLE`, `in_valid`=1: capture inputs.
    - Memory op with in-range address → `REQ`.
    - Otherwise → `DONE`.
  - `REQ`: `mem_req`=1; `mem_we`/`mem_addr`/`mem_wdata` held stable from the registered inputs.
    - `mem_ack`=1 → capture `mem_rdata` if read → `DONE`.
    - Timeout counter reaches `TIMEOUT` → `DONE` with `SADR`.
  - `DONE`: `done`=1 for exactly one cycle → `IDLE`.
- **Status priority:**
  1. `instr_valid`=0 → `SINS`; no memory access.
  2. Address `>= MEM_BYTES` → `SADR`; no request issued.
  3. Timeout → `SADR`.
  4. `icode==IHALT` → `SHLT`.
  5. Otherwise `SAOK`.
- **Address check:** unsigned 64-bit compare. A wrapped negative `valE` (e.g. push with `rsp`=0) faults.
- **`valM`:** holds the last completed read. Cleared to 0 on capture of a non-read instruction or on a faulting read.

## Timing
- **Reset values:** state `IDLE`, `in_ready`=1, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `valM`=0, `stat`=`SAOK`, `done`=0, timeout counter 0.
- **`in_ready`:** `in_ready` = (state==`IDLE`). `in_valid` is ignored outside `IDLE`.
- **Latency, non-memory or faulting-at-capture:** `done` 1 cycle after the accept edge.
- **Latency, memory op:** `mem_req` rises the cycle after accept.
  - `mem_ack` in the first `REQ` cycle → `done` next cycle; minimum 2 cycles from accept to `done`.
- **Timeout:**
  - Counter increments each `REQ` cycle without ack.
  - `TIMEOUT` unacknowledged `REQ` cycles → `DONE`; `mem_req` drops the same edge.
  - If `mem_ack` arrives in the same cycle as the timeout, ack wins and status is `SAOK`.
- **Stray ack:** `mem_ack` in `IDLE`/`DONE` is ignored.
- **Reset mid-`REQ`:** state → `IDLE`, `mem_req`=0 next cycle; no `done`.
- **Back-to-back:** a new instruction is accepted at the earliest in the cycle after `done`.

## Structure
- Shared `defines.vh` additions:
  - Status codes `SAOK`/`SHLT`/`SADR`/`SINS`.
  - FSM state encodings.
  - Reuse existing `QWORD` and icode constants.
- **Sub-module `mem_ctl_decode`:** combinational decode `icode`, `valE`, `valA`, `valP` → `is_read`, `is_write`, `addr`, `wdata`. Shared later with the pipelined M stage.
- **`mem_access`:** owns the FSM, input capture registers, timeout counter and output registers.

## Test plan
- **Read:** `IMRMOVQ`, `valE`=0x100, ack in first `REQ` cycle with `mem_rdata`=0xDEADBEEF → `mem_addr`=0x100, `mem_we`=0; `done` 2 cycles after accept, `valM`=0xDEADBEEF, `stat`=1.
- **Write:** `ICALL`, `valE`=0x1F8, `valP`=0x40, ack after 3 cycles → `mem_we`=1, `mem_wdata`=0x40, `mem_req` high 3 cycles, then `done`, `stat`=1.
- **Pop address:** `IPOPQ`, `valA`=0x200, `valE`=0x208 → `mem_addr`=0x200.
- **Address fault:** `IPUSHQ` with `valE`=0xFFFFFFFFFFFFFFF8 → no `mem_req`, `done` 1 cycle after accept, `stat`=3.
- **Timeout:**
  - No ack, `TIMEOUT`=15 → `mem_req` high exactly 15 cycles, then `done` with `stat`=3, `valM`=0.
  - Ack on cycle 15 → `stat`=1.
- **Non-memory/halt/illegal:**
  - `IOPQ` → `done` after 1 cycle, `stat`=1.
  - `IHALT` → `stat`=2.
  - `instr_valid`=0 with `IMRMOVQ` → `stat`=4, no request.
- **Reset and stray ack:**
  - Assert `rst` on 2nd `REQ` cycle → `mem_req`=0 and `in_ready`=1 next cycle, no `done`.
  - Stray `mem_ack` in `IDLE` has no effect.
